// File: rtl/mask_stats_pkg.sv
// Shared widths, FSM encoding and helpers for the mask statistics blocks.
package mask_stats_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COUNT_W = 20;
  localparam int unsigned SUM_W   = 30;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {
    StIdle,
    StSnap,
    StCalc,
    StDone
  } state_e;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + COORD_W'(1);
  endfunction

endpackage

// File: rtl/mask_centroid_if.sv
// Mask stream input and per-frame result bundle for mask_centroid.
interface mask_centroid_if;
  import mask_stats_pkg::*;

  logic               ce;
  logic               mask;
  logic               in_de;
  logic               in_hsync;
  logic               in_vsync;
  logic               result_valid;
  logic [COUNT_W-1:0] pix_count;
  logic [COORD_W-1:0] cent_x;
  logic [COORD_W-1:0] cent_y;
  logic [COORD_W-1:0] x_min;
  logic [COORD_W-1:0] x_max;
  logic [COORD_W-1:0] y_min;
  logic [COORD_W-1:0] y_max;
  logic               empty;
  logic               overrun;

  modport master (
    output ce, mask, in_de, in_hsync, in_vsync,
    input  result_valid, pix_count, cent_x, cent_y, x_min, x_max, y_min, y_max, empty, overrun
  );

  modport slave (
    input  ce, mask, in_de, in_hsync, in_vsync,
    output result_valid, pix_count, cent_x, cent_y, x_min, x_max, y_min, y_max, empty, overrun
  );

endinterface

// File: rtl/serial_divider.sv
// Fixed-latency restoring divider: one quotient bit per cycle, SUM_W cycles per division.
module serial_divider
  import mask_stats_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SUM_W-1:0]   dividend,
  input  logic [COUNT_W-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] quotient
);

  localparam int unsigned CntW = $clog2(SUM_W);

  logic               busy_q;
  logic [CntW-1:0]    cnt_q;
  logic [SUM_W-1:0]   quo_q;
  logic [COUNT_W-1:0] rem_q;
  logic [COUNT_W-1:0] dvs_q;
  logic [COUNT_W:0]   trial;
  logic [COUNT_W:0]   diff;
  logic               fits;

  always_comb begin
    trial = {rem_q, quo_q[SUM_W-1]};
    diff  = trial - {1'b0, dvs_q};
    fits  = (trial >= {1'b0, dvs_q});
  end

  // done flags the cycle whose clock edge retires the last quotient bit
  assign done     = busy_q && (cnt_q == CntW'(SUM_W - 1));
  assign busy     = busy_q;
  assign quotient = quo_q[COORD_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      rem_q  <= fits ? diff[COUNT_W-1:0] : trial[COUNT_W-1:0];
      quo_q  <= {quo_q[SUM_W-2:0], fits};
      cnt_q  <= cnt_q + CntW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mask_centroid.sv
// Per-frame mask statistics: count, centroid and bounding box with a result strobe.
// Define MASK_CENTROID_BBOX_EN to build the bounding-box logic; otherwise the box reads 0.
module mask_centroid
  import mask_stats_pkg::*;
#(
  parameter int unsigned H_SIZE = 64,
  parameter int unsigned V_SIZE = 64
) (
  input logic            clk,
  input logic            rst,
  mask_centroid_if.slave bus
);

  localparam logic [COORD_W-1:0] HLim = COORD_W'(H_SIZE);
  localparam logic [COORD_W-1:0] VLim = COORD_W'(V_SIZE);

  state_e             state_q, state_d;
  logic               vs_q, de_q, rise_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COUNT_W-1:0] acc_cnt_q, snap_cnt_q;
  logic [SUM_W-1:0]   acc_sx_q, acc_sy_q;
  logic               vs_rise, de_fall, hit, acc_clr, div_start;
  logic               busy_x, busy_y, done_x, done_y;
  logic [COORD_W-1:0] quo_x, quo_y;
  logic [COORD_W-1:0] snap_xmin, snap_xmax, snap_ymin, snap_ymax;

  logic               result_valid_q, overrun_q, empty_q;
  logic [COUNT_W-1:0] pix_count_q;
  logic [COORD_W-1:0] cent_x_q, cent_y_q, x_min_q, x_max_q, y_min_q, y_max_q;

  logic unused_sig;
  assign unused_sig = bus.in_hsync ^ busy_x ^ busy_y;

  assign vs_rise = bus.ce && bus.in_vsync && !vs_q;
  assign de_fall = bus.ce && !bus.in_de && de_q;
  assign hit     = bus.ce && bus.in_de && bus.mask && (x_q < HLim) && (y_q < VLim);
  // A frame end seen while busy still restarts accumulation for the following frame
  assign acc_clr = (state_q == StSnap) || (rise_q && state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q   <= 1'b0;
      de_q   <= 1'b0;
      rise_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      rise_q <= vs_rise;
      if (bus.ce) begin
        vs_q <= bus.in_vsync;
        de_q <= bus.in_de;
        if (bus.in_de) x_q <= sat_inc(x_q);
        else if (de_q) x_q <= '0;
        if (vs_rise) y_q <= '0;
        else if (de_fall) y_q <= sat_inc(y_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_q <= '0;
      acc_sx_q  <= '0;
      acc_sy_q  <= '0;
    end else if (acc_clr) begin
      acc_cnt_q <= '0;
      acc_sx_q  <= '0;
      acc_sy_q  <= '0;
    end else if (hit) begin
      acc_cnt_q <= acc_cnt_q + COUNT_W'(1);
      acc_sx_q  <= acc_sx_q + SUM_W'(x_q);
      acc_sy_q  <= acc_sy_q + SUM_W'(y_q);
    end
  end

`ifdef MASK_CENTROID_BBOX_EN
  logic [COORD_W-1:0] bb_xmin_q, bb_xmax_q, bb_ymin_q, bb_ymax_q;
  logic [COORD_W-1:0] sn_xmin_q, sn_xmax_q, sn_ymin_q, sn_ymax_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bb_xmin_q <= COORD_MAX;
      bb_xmax_q <= '0;
      bb_ymin_q <= COORD_MAX;
      bb_ymax_q <= '0;
      sn_xmin_q <= COORD_MAX;
      sn_xmax_q <= '0;
      sn_ymin_q <= COORD_MAX;
      sn_ymax_q <= '0;
    end else begin
      if (acc_clr) begin
        bb_xmin_q <= COORD_MAX;
        bb_xmax_q <= '0;
        bb_ymin_q <= COORD_MAX;
        bb_ymax_q <= '0;
      end else if (hit) begin
        if (x_q < bb_xmin_q) bb_xmin_q <= x_q;
        if (x_q > bb_xmax_q) bb_xmax_q <= x_q;
        if (y_q < bb_ymin_q) bb_ymin_q <= y_q;
        if (y_q > bb_ymax_q) bb_ymax_q <= y_q;
      end
      if (state_q == StSnap) begin
        sn_xmin_q <= bb_xmin_q;
        sn_xmax_q <= bb_xmax_q;
        sn_ymin_q <= bb_ymin_q;
        sn_ymax_q <= bb_ymax_q;
      end
    end
  end

  assign snap_xmin = sn_xmin_q;
  assign snap_xmax = sn_xmax_q;
  assign snap_ymin = sn_ymin_q;
  assign snap_ymax = sn_ymax_q;
`else
  assign snap_xmin = '0;
  assign snap_xmax = '0;
  assign snap_ymin = '0;
  assign snap_ymax = '0;
`endif

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    unique case (state_q)
      StIdle: if (rise_q) state_d = StSnap;
      StSnap: begin
        if (acc_cnt_q == '0) begin
          state_d = StDone;
        end else begin
          state_d   = StCalc;
          div_start = 1'b1;
        end
      end
      StCalc: if (done_x && done_y) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      snap_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StSnap) snap_cnt_q <= acc_cnt_q;
    end
  end

  serial_divider u_div_x (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc_sx_q),
    .divisor  (acc_cnt_q),
    .busy     (busy_x),
    .done     (done_x),
    .quotient (quo_x)
  );

  serial_divider u_div_y (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc_sy_q),
    .divisor  (acc_cnt_q),
    .busy     (busy_y),
    .done     (done_y),
    .quotient (quo_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      empty_q        <= 1'b0;
      pix_count_q    <= '0;
      cent_x_q       <= '0;
      cent_y_q       <= '0;
      x_min_q        <= '0;
      x_max_q        <= '0;
      y_min_q        <= '0;
      y_max_q        <= '0;
    end else begin
      result_valid_q <= (state_q == StDone);
      overrun_q      <= rise_q && (state_q != StIdle);
      if (state_q == StDone) begin
        pix_count_q <= snap_cnt_q;
        empty_q     <= (snap_cnt_q == '0);
        if (snap_cnt_q == '0) begin
          cent_x_q <= '0;
          cent_y_q <= '0;
          x_min_q  <= '0;
          x_max_q  <= '0;
          y_min_q  <= '0;
          y_max_q  <= '0;
        end else begin
          cent_x_q <= quo_x;
          cent_y_q <= quo_y;
          x_min_q  <= snap_xmin;
          x_max_q  <= snap_xmax;
          y_min_q  <= snap_ymin;
          y_max_q  <= snap_ymax;
        end
      end
    end
  end

  assign bus.result_valid = result_valid_q;
  assign bus.overrun      = overrun_q;
  assign bus.empty        = empty_q;
  assign bus.pix_count    = pix_count_q;
  assign bus.cent_x       = cent_x_q;
  assign bus.cent_y       = cent_y_q;
  assign bus.x_min        = x_min_q;
  assign bus.x_max        = x_max_q;
  assign bus.y_min        = y_min_q;
  assign bus.y_max        = y_max_q;

endmodule

// File: tb/tb_mask_centroid.sv
// Directed-vector bench for mask_centroid on an 8x8 active window (9x9 frames driven).
module tb_mask_centroid;

`ifdef MASK_CENTROID_BBOX_EN
  localparam bit BboxEn = 1'b1;
`else
  localparam bit BboxEn = 1'b0;
`endif

  typedef struct {
    bit [80:0] img;
    bit        ce_tog;
    int        cnt, cx, cy, xmin, xmax, ymin, ymax, emp, lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  mask_centroid_if bus_if ();

  mask_centroid #(
    .H_SIZE (8),
    .V_SIZE (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  function automatic bit [80:0] pix(input int x, input int y);
    bit [80:0] r;
    r = '0;
    r[y*9+x] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_lines(input bit [80:0] img, input bit ce_tog);
    for (int y = 0; y < 9; y++) begin
      for (int x = 0; x < 9; x++) begin
        bus_if.ce = 1'b1; bus_if.in_de = 1'b1; bus_if.mask = img[y*9+x];
        step();
        if (ce_tog) begin
          // garbage that must not be sampled while ce is low
          bus_if.ce = 1'b0; bus_if.in_de = 1'b1; bus_if.mask = 1'b1;
          step();
        end
      end
      bus_if.ce = 1'b1; bus_if.in_de = 1'b0; bus_if.mask = 1'b0; bus_if.in_hsync = 1'b1;
      step();
      bus_if.in_hsync = 1'b0;
      step();
    end
  endtask

  task automatic vsync_edge(output int t0);
    bus_if.ce = 1'b1; bus_if.in_vsync = 1'b1;
    step();
    t0 = cyc;
    bus_if.in_vsync = 1'b0;
  endtask

  task automatic wait_result(input int t0, output int lat, output int ovr);
    lat = -1;
    ovr = 0;
    for (int i = 0; i < 80 && lat < 0; i++) begin
      @(negedge clk);
      if (bus_if.overrun) ovr++;
      if (bus_if.result_valid) lat = cyc - t0;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    chk({tag, " pix_count"}, int'(bus_if.pix_count), v.cnt);
    chk({tag, " cent_x"}, int'(bus_if.cent_x), v.cx);
    chk({tag, " cent_y"}, int'(bus_if.cent_y), v.cy);
    chk({tag, " x_min"}, int'(bus_if.x_min), BboxEn ? v.xmin : 0);
    chk({tag, " x_max"}, int'(bus_if.x_max), BboxEn ? v.xmax : 0);
    chk({tag, " y_min"}, int'(bus_if.y_min), BboxEn ? v.ymin : 0);
    chk({tag, " y_max"}, int'(bus_if.y_max), BboxEn ? v.ymax : 0);
    chk({tag, " empty"}, int'(bus_if.empty), v.emp);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int t0, lat, ovr;
    send_lines(v.img, v.ce_tog);
    vsync_edge(t0);
    wait_result(t0, lat, ovr);
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " overrun"}, ovr, 0);
    check_result(tag, v);
    @(negedge clk);
    chk({tag, " valid_pulse"}, int'(bus_if.result_valid), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int t0, lat, ovr, nvalid;

    vecs[0] = '{img: pix(3, 2), ce_tog: 0, cnt: 1, cx: 3, cy: 2,
                xmin: 3, xmax: 3, ymin: 2, ymax: 2, emp: 0, lat: 33};
    vecs[1] = '{img: pix(4, 1) | pix(5, 1) | pix(4, 2) | pix(5, 2), ce_tog: 0, cnt: 4,
                cx: 4, cy: 1, xmin: 4, xmax: 5, ymin: 1, ymax: 2, emp: 0, lat: 33};
    vecs[2] = '{img: '0, ce_tog: 0, cnt: 0, cx: 0, cy: 0,
                xmin: 0, xmax: 0, ymin: 0, ymax: 0, emp: 1, lat: 3};
    vecs[3] = '{img: pix(8, 1) | pix(2, 8) | pix(8, 8) | pix(1, 1) | pix(6, 5), ce_tog: 0,
                cnt: 2, cx: 3, cy: 3, xmin: 1, xmax: 6, ymin: 1, ymax: 5, emp: 0, lat: 33};
    vecs[4] = '{img: pix(0, 0) | pix(7, 7) | pix(2, 4), ce_tog: 1, cnt: 3, cx: 3, cy: 3,
                xmin: 0, xmax: 7, ymin: 0, ymax: 7, emp: 0, lat: 33};
    vecs[5] = vecs[4];
    vecs[5].ce_tog = 0;
    vecs[6] = '{img: '0, ce_tog: 0, cnt: 8, cx: 3, cy: 7,
                xmin: 0, xmax: 7, ymin: 7, ymax: 7, emp: 0, lat: 33};
    for (int x = 0; x < 8; x++) vecs[6].img |= pix(x, 7);

    bus_if.ce = 1'b0; bus_if.mask = 1'b0; bus_if.in_de = 1'b0;
    bus_if.in_hsync = 1'b0; bus_if.in_vsync = 1'b0;
    #1 rst = 1'b1;
    repeat (3) step();
    chk("reset result_valid", int'(bus_if.result_valid), 0);
    chk("reset overrun", int'(bus_if.overrun), 0);
    chk("reset empty", int'(bus_if.empty), 0);
    chk("reset pix_count", int'(bus_if.pix_count), 0);
    chk("reset cent_x", int'(bus_if.cent_x), 0);
    chk("reset cent_y", int'(bus_if.cent_y), 0);
    chk("reset x_min", int'(bus_if.x_min), 0);
    chk("reset y_min", int'(bus_if.y_min), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Second frame end 10 cycles after the first: overrun, first result unaffected
    send_lines(vecs[0].img, 1'b0);
    vsync_edge(t0);
    repeat (9) step();
    bus_if.in_vsync = 1'b1;
    step();
    bus_if.in_vsync = 1'b0;
    wait_result(t0, lat, ovr);
    chk("ovr latency", lat, 33);
    chk("ovr overrun_pulses", ovr, 1);
    check_result("ovr", vecs[0]);
    repeat (5) step();

    // Reset while the dividers are running: outputs clear at once, no strobe follows
    run_vec("pre_rst", vecs[1]);
    send_lines(vecs[0].img, 1'b0);
    vsync_edge(t0);
    repeat (10) step();
    #2 rst = 1'b1;
    #1;
    chk("rst_calc pix_count", int'(bus_if.pix_count), 0);
    chk("rst_calc cent_x", int'(bus_if.cent_x), 0);
    chk("rst_calc cent_y", int'(bus_if.cent_y), 0);
    chk("rst_calc x_max", int'(bus_if.x_max), 0);
    chk("rst_calc y_max", int'(bus_if.y_max), 0);
    repeat (3) step();
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_if.result_valid) nvalid++;
    end
    chk("rst_calc no_valid", nvalid, 0);
    step();

    run_vec("post_rst", vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
